// File: rtl/line_capture_buf.sv
`default_nettype none
// ============================================================================
//  Module      : line_capture_buf
//  Description : Two-bank ping-pong line buffer. The writer side captures one
//                video line per bank and tags it with a line index. The reader
//                side presents completed lines in capture order through a
//                show-ahead FIFO-style handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module line_capture_buf #(
    parameter int DATA_W     = 16,
    parameter int LINE_PIX   = 512,
    parameter int PTR_W      = 9,
    parameter int LINE_IDX_W = 9
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_frame_start,
    input  logic                  i_line_start,
    input  logic                  i_pix_valid,
    input  logic [DATA_W-1:0]     i_pix_data,
    output logic                  o_fifo_nempty,
    output logic [LINE_IDX_W-1:0] o_fifo_line,
    output logic [DATA_W-1:0]     o_fifo_data,
    input  logic                  i_fifo_next,
    input  logic                  i_fifo_reset,
    output logic                  o_drop,
    output logic                  o_line_err,
    output logic [7:0]            o_drop_cnt
);

    localparam logic [1:0] BANK_FREE    = 2'd0;
    localparam logic [1:0] BANK_FILLING = 2'd1;
    localparam logic [1:0] BANK_FULL    = 2'd2;

    localparam logic [1:0] WR_IDLE = 2'd0;
    localparam logic [1:0] WR_FILL = 2'd1;
    localparam logic [1:0] WR_SKIP = 2'd2;

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(LINE_PIX - 1);

    // Line storage: bank index is the address MSB.
    logic [DATA_W-1:0]           mem_q [0:2*LINE_PIX-1];

    logic [1:0][1:0]             bank_st_q, bank_st_d;
    logic [1:0][LINE_IDX_W-1:0]  tag_q, tag_d;
    logic [1:0]                  wr_st_q, wr_st_d;
    logic                        wr_bank_q, wr_bank_d;
    logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
    logic [LINE_IDX_W-1:0]       line_cnt_q, line_cnt_d;
    logic                        newest_q, newest_d;
    logic                        rd_valid_q, rd_valid_d;
    logic                        rd_bank_q, rd_bank_d;
    logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
    logic                        drop_q, drop_d;
    logic                        err_q, err_d;
    logic [7:0]                  drop_cnt_q, drop_cnt_d;
    logic [DATA_W-1:0]           data_q;

    logic                        start;
    logic                        release_rd;
    logic                        mem_we;
    logic                        completing;

    // A frame start doubles as the start of line 0.
    assign start      = i_frame_start | i_line_start;
    // Releasing is only meaningful while a read bank is presented.
    assign release_rd = i_fifo_reset & rd_valid_q;

    // Next-state logic for bank states, writer FSM and reader selection.
    always_comb begin
        bank_st_d  = bank_st_q;
        tag_d      = tag_q;
        wr_st_d    = wr_st_q;
        wr_bank_d  = wr_bank_q;
        wr_ptr_d   = wr_ptr_q;
        line_cnt_d = line_cnt_q;
        newest_d   = newest_q;
        rd_valid_d = rd_valid_q;
        rd_bank_d  = rd_bank_q;
        rd_ptr_d   = rd_ptr_q;
        drop_d     = 1'b0;
        err_d      = 1'b0;
        drop_cnt_d = drop_cnt_q;
        mem_we     = 1'b0;
        completing = 1'b0;

        // Release first so a start in the same cycle sees the bank as free.
        if (release_rd) begin
            bank_st_d[rd_bank_q] = BANK_FREE;
        end

        if (start) begin
            line_cnt_d = i_frame_start ? '0 : line_cnt_q + 1'b1;
            // A bank still filling is necessarily short: discard it.
            if (wr_st_q == WR_FILL) begin
                bank_st_d[wr_bank_q] = BANK_FREE;
                err_d                = 1'b1;
            end
            if (bank_st_d[0] == BANK_FREE || bank_st_d[1] == BANK_FREE) begin
                wr_bank_d            = (bank_st_d[0] != BANK_FREE);
                bank_st_d[wr_bank_d] = BANK_FILLING;
                tag_d[wr_bank_d]     = line_cnt_d;
                wr_ptr_d             = '0;
                wr_st_d              = WR_FILL;
            end else begin
                drop_d  = 1'b1;
                wr_st_d = WR_SKIP;
            end
        end else if (wr_st_q == WR_FILL && i_pix_valid) begin
            // Pixels arriving in a start cycle are ignored (handled above).
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (wr_ptr_q == PTR_LAST) begin
                bank_st_d[wr_bank_q] = BANK_FULL;
                newest_d             = wr_bank_q;
                wr_st_d              = WR_SKIP;
                completing           = 1'b1;
            end
        end

        if (release_rd) begin
            // Hand over to the other bank if it is full or completes right now.
            rd_ptr_d = '0;
            if (bank_st_q[~rd_bank_q] == BANK_FULL || completing) begin
                rd_valid_d = 1'b1;
                rd_bank_d  = ~rd_bank_q;
            end else begin
                rd_valid_d = 1'b0;
            end
        end else if (rd_valid_q) begin
            if (i_fifo_next && rd_ptr_q != PTR_LAST) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
        end else if (bank_st_q[0] == BANK_FULL || bank_st_q[1] == BANK_FULL) begin
            rd_valid_d = 1'b1;
            if (bank_st_q[0] == BANK_FULL && bank_st_q[1] == BANK_FULL) begin
                rd_bank_d = ~newest_q;
            end else begin
                rd_bank_d = (bank_st_q[1] == BANK_FULL);
            end
        end

        if ((drop_d || err_d) && drop_cnt_q != 8'hFF) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    // State registers and the show-ahead read port (addressed with next pointer).
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            bank_st_q  <= {BANK_FREE, BANK_FREE};
            tag_q      <= '0;
            wr_st_q    <= WR_IDLE;
            wr_bank_q  <= 1'b0;
            wr_ptr_q   <= '0;
            line_cnt_q <= '0;
            newest_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_bank_q  <= 1'b0;
            rd_ptr_q   <= '0;
            drop_q     <= 1'b0;
            err_q      <= 1'b0;
            drop_cnt_q <= '0;
            data_q     <= '0;
        end else begin
            bank_st_q  <= bank_st_d;
            tag_q      <= tag_d;
            wr_st_q    <= wr_st_d;
            wr_bank_q  <= wr_bank_d;
            wr_ptr_q   <= wr_ptr_d;
            line_cnt_q <= line_cnt_d;
            newest_q   <= newest_d;
            rd_valid_q <= rd_valid_d;
            rd_bank_q  <= rd_bank_d;
            rd_ptr_q   <= rd_ptr_d;
            drop_q     <= drop_d;
            err_q      <= err_d;
            drop_cnt_q <= drop_cnt_d;
            data_q     <= mem_q[{rd_bank_d, rd_ptr_d}];
        end
    end

    // Pixel write port; contents need no reset.
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            mem_q[{wr_bank_q, wr_ptr_q}] <= i_pix_data;
        end
    end

    assign o_fifo_nempty = rd_valid_q;
    assign o_fifo_line   = rd_valid_q ? tag_q[rd_bank_q] : '0;
    assign o_fifo_data   = data_q;
    assign o_drop        = drop_q;
    assign o_line_err    = err_q;
    assign o_drop_cnt    = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_line_capture_buf.sv
`default_nettype none
// ============================================================================
//  Module      : tb_line_capture_buf
//  Description : Self-checking bench for line_capture_buf: vector table,
//                directed multi-cycle sequences and randomized traffic, all
//                compared against a queue-based line model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_line_capture_buf;

    localparam int DATA_W   = 16;
    localparam int LINE_PIX = 512;
    localparam int IDX_W    = 9;
    localparam int NSLOT    = 8;

    logic              clk = 1'b0;
    logic              rst_n, fs, ls, pv, fnext, freset;
    logic [DATA_W-1:0] pd;
    logic              nempty, drop, lerr;
    logic [IDX_W-1:0]  line;
    logic [DATA_W-1:0] data;
    logic [7:0]        dcnt;

    always #5 clk = ~clk;

    line_capture_buf dut (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_frame_start (fs),
        .i_line_start  (ls),
        .i_pix_valid   (pv),
        .i_pix_data    (pd),
        .o_fifo_nempty (nempty),
        .o_fifo_line   (line),
        .o_fifo_data   (data),
        .i_fifo_next   (fnext),
        .i_fifo_reset  (freset),
        .o_drop        (drop),
        .o_line_err    (lerr),
        .o_drop_cnt    (dcnt)
    );

    int errors = 0;
    int checks = 0;

    // Line-level model: completed lines kept in a capture-order queue.
    logic [DATA_W-1:0] m_pix [NSLOT][LINE_PIX];
    logic [IDX_W-1:0]  m_tag [NSLOT];
    int                m_done_q[$];
    int                m_next_slot = 0;
    int                m_cur = 0;
    int                m_npix = 0;
    bit                m_filling = 0;
    bit                m_vis = 0;
    int                m_ptr = 0;
    int                m_line_cnt = 0;
    bit                m_drop = 0;
    bit                m_err = 0;
    int                m_dcnt = 0;

    task automatic model_step();
        int pre;
        bit rel;
        m_drop = 0;
        m_err  = 0;
        if (!rst_n) begin
            m_done_q.delete();
            m_filling = 0; m_vis = 0; m_ptr = 0; m_line_cnt = 0; m_dcnt = 0;
            return;
        end
        pre = m_done_q.size();
        rel = 0;
        if (freset && m_vis) begin
            void'(m_done_q.pop_front());
            m_ptr = 0;
            rel   = 1;
        end else if (m_vis && fnext && m_ptr < LINE_PIX - 1) begin
            m_ptr++;
        end
        if (fs || ls) begin
            m_line_cnt = fs ? 0 : (m_line_cnt + 1) % (1 << IDX_W);
            if (m_filling) begin
                m_filling = 0;
                m_err     = 1;
            end
            if (m_done_q.size() < 2) begin
                m_filling   = 1;
                m_cur       = m_next_slot;
                m_next_slot = (m_next_slot + 1) % NSLOT;
                m_tag[m_cur] = IDX_W'(m_line_cnt);
                m_npix      = 0;
            end else begin
                m_drop = 1;
            end
        end else if (m_filling && pv) begin
            m_pix[m_cur][m_npix] = pd;
            m_npix++;
            if (m_npix == LINE_PIX) begin
                m_done_q.push_back(m_cur);
                m_filling = 0;
            end
        end
        if (rel) m_vis = (m_done_q.size() > 0);
        else if (!m_vis && pre > 0) m_vis = 1;
        if ((m_drop || m_err) && m_dcnt < 255) m_dcnt++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_model();
        chk("nempty", {31'd0, nempty}, {31'd0, m_vis});
        chk("drop", {31'd0, drop}, {31'd0, m_drop});
        chk("line_err", {31'd0, lerr}, {31'd0, m_err});
        chk("drop_cnt", {24'd0, dcnt}, m_dcnt);
        if (m_vis) begin
            chk("line", {23'd0, line}, {23'd0, m_tag[m_done_q[0]]});
            chk("data", {16'd0, data}, {16'd0, m_pix[m_done_q[0]][m_ptr]});
        end
    endtask

    task automatic cycle(input bit r_n, input bit f, input bit l, input bit v,
                         input logic [DATA_W-1:0] d, input bit n, input bit rs);
        rst_n = r_n; fs = f; ls = l; pv = v; pd = d; fnext = n; freset = rs;
        @(posedge clk);
        model_step();
        #1;
        cmp_model();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, '0, 0, 0);
    endtask

    task automatic do_reset();
        cycle(0, 0, 0, 0, '0, 0, 0);
        cycle(0, 0, 0, 0, '0, 0, 0);
    endtask

    task automatic pixels(input int base, input int n);
        for (int i = 0; i < n; i++) cycle(1, 0, 0, 1, DATA_W'(base + i), 0, 0);
    endtask

    typedef struct {
        bit f, l, v, n, rs;
        logic [DATA_W-1:0] d;
        bit e_nempty, e_drop, e_err;
        logic [7:0] e_cnt;
    } vec_t;

    vec_t vt [9];

    initial begin
        // Start-pulse bookkeeping straight out of reset.
        vt[0] = '{0,0,0,0,0, 16'h0,    0,0,0, 8'd0};
        vt[1] = '{1,0,0,0,0, 16'h0,    0,0,0, 8'd0};
        vt[2] = '{0,1,0,0,0, 16'h0,    0,0,1, 8'd1};
        vt[3] = '{0,0,0,0,0, 16'h0,    0,0,0, 8'd1};
        vt[4] = '{0,0,1,0,0, 16'h5,    0,0,0, 8'd1};
        vt[5] = '{0,1,0,0,0, 16'h0,    0,0,1, 8'd2};
        vt[6] = '{0,0,0,0,1, 16'h0,    0,0,0, 8'd2};
        vt[7] = '{1,1,0,0,0, 16'h0,    0,0,1, 8'd3};
        vt[8] = '{0,0,0,1,0, 16'h0,    0,0,0, 8'd3};

        do_reset();
        chk("rst_nempty", {31'd0, nempty}, 32'd0);
        chk("rst_line", {23'd0, line}, 32'd0);
        chk("rst_data", {16'd0, data}, 32'd0);
        chk("rst_cnt", {24'd0, dcnt}, 32'd0);

        for (int i = 0; i < 9; i++) begin
            cycle(1, vt[i].f, vt[i].l, vt[i].v, vt[i].d, vt[i].n, vt[i].rs);
            chk($sformatf("tbl%0d_nempty", i), {31'd0, nempty}, {31'd0, vt[i].e_nempty});
            chk($sformatf("tbl%0d_drop", i), {31'd0, drop}, {31'd0, vt[i].e_drop});
            chk($sformatf("tbl%0d_err", i), {31'd0, lerr}, {31'd0, vt[i].e_err});
            chk($sformatf("tbl%0d_cnt", i), {24'd0, dcnt}, {24'd0, vt[i].e_cnt});
        end

        // Single line capture and full drain.
        do_reset();
        cycle(1, 1, 0, 0, '0, 0, 0);
        pixels(0, LINE_PIX);
        chk("t1_latency_early", {31'd0, nempty}, 32'd0);
        idle(1);
        chk("t1_nempty", {31'd0, nempty}, 32'd1);
        chk("t1_line", {23'd0, line}, 32'd0);
        chk("t1_data0", {16'd0, data}, 32'd0);
        for (int i = 0; i < LINE_PIX; i++) cycle(1, 0, 0, 0, '0, 1, 0);
        chk("t1_data_sat", {16'd0, data}, 32'd511);
        cycle(1, 0, 0, 0, '0, 0, 1);
        chk("t1_released", {31'd0, nempty}, 32'd0);

        // Two lines buffered, a third dropped, capture order preserved.
        cycle(1, 1, 0, 0, '0, 0, 0);
        pixels(1000, LINE_PIX);
        cycle(1, 0, 1, 0, '0, 0, 0);
        pixels(2000, LINE_PIX);
        idle(2);
        chk("t2_line_first", {23'd0, line}, 32'd0);
        chk("t2_data_first", {16'd0, data}, 32'd1000);
        cycle(1, 0, 1, 0, '0, 0, 0);
        chk("t3_drop", {31'd0, drop}, 32'd1);
        chk("t3_cnt", {24'd0, dcnt}, 32'd1);
        pixels(3000, LINE_PIX);
        chk("t3_drop_pulse", {31'd0, drop}, 32'd0);
        cycle(1, 0, 0, 0, '0, 0, 1);
        chk("t2_stay_nempty", {31'd0, nempty}, 32'd1);
        chk("t2_line_second", {23'd0, line}, 32'd1);
        chk("t3_data_kept", {16'd0, data}, 32'd2000);
        cycle(1, 0, 0, 0, '0, 0, 1);
        chk("t2_empty", {31'd0, nempty}, 32'd0);

        // Short line discarded and replaced.
        cycle(1, 0, 1, 0, '0, 0, 0);
        pixels(500, 300);
        cycle(1, 0, 1, 0, '0, 0, 0);
        chk("t4_err", {31'd0, lerr}, 32'd1);
        chk("t4_cnt", {24'd0, dcnt}, 32'd2);
        pixels(4000, LINE_PIX);
        idle(2);
        chk("t4_line", {23'd0, line}, 32'd4);
        chk("t4_data", {16'd0, data}, 32'd4000);

        // Start coincident with release while both banks are full.
        cycle(1, 0, 1, 0, '0, 0, 0);
        pixels(5000, LINE_PIX);
        idle(2);
        cycle(1, 0, 1, 0, '0, 0, 1);
        chk("t5_no_drop", {31'd0, drop}, 32'd0);
        chk("t5_line", {23'd0, line}, 32'd5);
        chk("t5_data", {16'd0, data}, 32'd5000);
        pixels(6000, LINE_PIX);
        idle(2);
        cycle(1, 0, 0, 0, '0, 0, 1);
        chk("t5_line_new", {23'd0, line}, 32'd6);

        // Reset in the middle of a drain.
        for (int i = 0; i < 200; i++) cycle(1, 0, 0, 0, '0, 1, 0);
        chk("t6_data200", {16'd0, data}, 32'd6200);
        cycle(0, 0, 0, 0, '0, 0, 0);
        chk("t6_nempty", {31'd0, nempty}, 32'd0);
        chk("t6_cnt", {24'd0, dcnt}, 32'd0);
        cycle(1, 1, 0, 0, '0, 0, 0);
        pixels(7000, LINE_PIX);
        idle(2);
        chk("t6_line", {23'd0, line}, 32'd0);
        chk("t6_data", {16'd0, data}, 32'd7000);

        // Randomized traffic on both sides.
        do_reset();
        for (int ln = 0; ln < 40; ln++) begin
            int  npix;
            int  sent;
            int  sel;
            bit  f, l;
            if ($urandom_range(0, 39) == 0) cycle(0, 0, 0, 0, '0, 0, 0);
            sel = $urandom_range(0, 9);
            f = (sel == 0) || (sel == 1);
            l = (sel != 0);
            npix = ($urandom_range(0, 3) == 0) ? $urandom_range(1, LINE_PIX - 1) : LINE_PIX;
            cycle(1, f, l, $urandom_range(0, 1) == 1, DATA_W'($urandom),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 149) == 0);
            sent = 0;
            while (sent < npix) begin
                bit v;
                v = ($urandom_range(0, 3) != 0);
                cycle(1, 0, 0, v, DATA_W'($urandom),
                      $urandom_range(0, 1) == 1, $urandom_range(0, 149) == 0);
                if (v) sent++;
            end
            for (int g = 0; g < $urandom_range(0, 20); g++)
                cycle(1, 0, 0, $urandom_range(0, 1) == 1, DATA_W'($urandom),
                      $urandom_range(0, 1) == 1, $urandom_range(0, 149) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
